// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative RISC-V M-extension multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } state_e;

  // Special-case results are sliced down to XLEN by the user.
  localparam int MAX_XLEN = 128;
  localparam logic [MAX_XLEN-1:0] DIV0_QUOTIENT = '1;
  localparam logic [MAX_XLEN-1:0] ZERO_RESULT   = '0;

  function automatic int iter_count(input int xlen, input int bpc);
    return xlen / bpc;
  endfunction

  function automatic int cnt_width(input int xlen, input int bpc);
    return $clog2(xlen / bpc) + 1;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: a shift-add multiply bit or a restoring-divide bit.
// hi/lo form one 2*XLEN register: accumulator/multiplier for multiply, remainder/quotient for divide.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            is_div_i,
  input  logic [XLEN-1:0] opnd_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0] mul_sum;
  logic [XLEN:0] mul_acc;
  logic [XLEN:0] div_shift;
  logic [XLEN:0] div_diff;
  logic          div_ge;

  assign mul_sum   = {1'b0, hi_i} + {1'b0, opnd_i};
  assign mul_acc   = lo_i[0] ? mul_sum : {1'b0, hi_i};

  // Remainder stays below the divisor, so the shifted value fits in XLEN+1 bits.
  assign div_shift = {hi_i, lo_i[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd_i};
  assign div_ge    = ~div_diff[XLEN];

  always_comb begin
    hi_o = hi_i;
    lo_o = lo_i;
    if (is_div_i) begin
      hi_o = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
      lo_o = {lo_i[XLEN-2:0], div_ge};
    end else begin
      {hi_o, lo_o} = {mul_acc, lo_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: IDLE -> CALC (N cycles) -> FIX -> DONE, valid/ready both sides.
// Defining MULDIV_ZERO_SKIP_EN sends multiplies by zero down the one-edge special-case path.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            Flush,
  input  logic            InValid,
  output logic            InReady,
  input  logic [2:0]      Op,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [XLEN-1:0] Result,
  output logic            Busy
);

  localparam int N     = iter_count(XLEN, BITS_PER_CYCLE);
  localparam int CNT_W = cnt_width(XLEN, BITS_PER_CYCLE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  ALL_ONES = DIV0_QUOTIENT[XLEN-1:0];
  localparam logic [XLEN-1:0]  ZERO     = ZERO_RESULT[XLEN-1:0];

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic              neg_q, neg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   result_q, result_d;

  op_e             op_in;
  logic            in_is_div;
  logic            a_sgn, b_sgn;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            neg_in;
  logic            div_zero, div_ovf, mul_zero, special;
  logic [XLEN-1:0] special_res;

  assign op_in     = op_e'(Op);
  assign in_is_div = Op[2];
  assign a_sgn     = (op_in == OP_MULH || op_in == OP_MULHSU ||
                      op_in == OP_DIV  || op_in == OP_REM) && SrcA[XLEN-1];
  assign b_sgn     = (op_in == OP_MULH || op_in == OP_DIV || op_in == OP_REM) && SrcB[XLEN-1];
  // The most-negative value negates to itself, which is its correct unsigned magnitude.
  assign mag_a     = a_sgn ? -SrcA : SrcA;
  assign mag_b     = b_sgn ? -SrcB : SrcB;
  assign neg_in    = (in_is_div && Op[1]) ? a_sgn : (a_sgn ^ b_sgn);

  assign div_zero  = in_is_div && (SrcB == ZERO);
  assign div_ovf   = (op_in == OP_DIV || op_in == OP_REM) && (SrcA == MOST_NEG) && (SrcB == ALL_ONES);
`ifdef MULDIV_ZERO_SKIP_EN
  assign mul_zero  = !in_is_div && (SrcA == ZERO || SrcB == ZERO);
`else
  assign mul_zero  = 1'b0;
`endif
  assign special   = div_zero || div_ovf || mul_zero;

  always_comb begin
    special_res = ZERO;
    if (div_zero) begin
      special_res = Op[1] ? SrcA : ALL_ONES;
    end else if (div_ovf) begin
      special_res = Op[1] ? ZERO : SrcA;
    end
  end

  logic [XLEN-1:0] hi_c [BITS_PER_CYCLE+1];
  logic [XLEN-1:0] lo_c [BITS_PER_CYCLE+1];

  assign hi_c[0] = hi_q;
  assign lo_c[0] = lo_q;

  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    muldiv_step #(.XLEN(XLEN)) u_step (
      .is_div_i (op_q[2]),
      .opnd_i   (opnd_q),
      .hi_i     (hi_c[g]),
      .lo_i     (lo_c[g]),
      .hi_o     (hi_c[g+1]),
      .lo_o     (lo_c[g+1])
    );
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

  assign prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
  assign quo_fix  = neg_q ? -lo_q : lo_q;
  assign rem_fix  = neg_q ? -hi_q : hi_q;

  always_comb begin
    fix_res = ZERO;
    case (op_q)
      OP_MUL:                         fix_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:   fix_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:                fix_res = quo_fix;
      OP_REM, OP_REMU:                fix_res = rem_fix;
      default:                        fix_res = ZERO;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;

    case (state_q)
      ST_IDLE: begin
        if (InValid && !Flush) begin
          op_d   = op_in;
          neg_d  = neg_in;
          cnt_d  = '0;
          opnd_d = in_is_div ? mag_b : mag_a;
          hi_d   = ZERO;
          lo_d   = in_is_div ? mag_a : mag_b;
          if (special) begin
            result_d = special_res;
            state_d  = ST_DONE;
          end else begin
            state_d  = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        hi_d  = hi_c[BITS_PER_CYCLE];
        lo_d  = lo_c[BITS_PER_CYCLE];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = ST_FIX;
      end
      ST_FIX: begin
        result_d = fix_res;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        if (OutReady) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush outranks OutReady and any in-flight work.
    if (Flush && state_q != ST_IDLE) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
    end
  end

  assign InReady  = (state_q == ST_IDLE);
  assign OutValid = (state_q == ST_DONE);
  assign Busy     = (state_q != ST_IDLE);
  assign Result   = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at XLEN=32, one bit per cycle: vector table plus corner sequences.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Flush = 1'b0;
  logic        InValid = 1'b0;
  logic        OutReady = 1'b0;
  logic [2:0]  Op = 3'b000;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic        InReady, OutValid, Busy;
  logic [31:0] Result;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Flush    (Flush),
    .InValid  (InValid),
    .InReady  (InReady),
    .Op       (Op),
    .SrcA     (SrcA),
    .SrcB     (SrcB),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Result   (Result),
    .Busy     (Busy)
  );

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Issue one op, then count edges after the accepting edge until OutValid.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output logic rdy_bad);
    @(negedge clk);
    Op = op; SrcA = a; SrcB = b; InValid = 1'b1;
    @(posedge clk);
    #1 InValid = 1'b0;
    lat = 0;
    rdy_bad = 1'b0;
    while (!OutValid && lat < 100) begin
      if (InReady) rdy_bad = 1'b1;
      @(posedge clk);
      #1 lat++;
    end
    res = Result;
  endtask

  task automatic drain();
    @(negedge clk);
    OutReady = 1'b1;
    @(posedge clk);
    #1 OutReady = 1'b0;
  endtask

  logic [31:0] res;
  int          lat;
  logic        rdy_bad;
  logic        bad;

  initial begin
    vecs[0]  = '{"MUL 7x-3",        3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    vecs[1]  = '{"MULH min*min",    3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33};
    vecs[2]  = '{"MULHU max*max",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vecs[3]  = '{"MULHSU -1*max",   3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
    vecs[4]  = '{"DIV -7/2",        3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
    vecs[5]  = '{"REM -7/2",        3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
    vecs[6]  = '{"DIVU big/2",      3'b101, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 33};
    vecs[7]  = '{"REMU big/2",      3'b111, 32'hFFFFFFF9, 32'd2,        32'h00000001, 33};
    vecs[8]  = '{"DIV 5/0",         3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 0};
    vecs[9]  = '{"REMU 5/0",        3'b111, 32'd5,        32'd0,        32'd5,        0};
    vecs[10] = '{"DIV ovf",         3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0};
    vecs[11] = '{"REM ovf",         3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0};
    vecs[12] = '{"DIVU 5/0",        3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 0};
    vecs[13] = '{"MUL 0x9",         3'b000, 32'd0,        32'd9,        32'd0,        33};

    #2;
    check("reset OutValid", {31'd0, OutValid}, 32'd0);
    check("reset Busy",     {31'd0, Busy},     32'd0);
    check("reset InReady",  {31'd0, InReady},  32'd1);
    check("reset Result",   Result,            32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, rdy_bad);
      check({vecs[i].name, " result"},  res,          vecs[i].exp);
      check({vecs[i].name, " latency"}, 32'(lat),     32'(vecs[i].lat));
      check({vecs[i].name, " InReady"}, {31'd0, rdy_bad}, 32'd0);
      drain();
      check({vecs[i].name, " drained"}, {31'd0, InReady}, 32'd1);
    end

    // Backpressure: result held stable while OutReady stays low, then flush from DONE.
    do_op(3'b100, 32'd100, 32'd7, res, lat, rdy_bad);
    check("hold result", res, 32'd14);
    bad = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1 if (!OutValid || !Busy || Result !== 32'd14) bad = 1'b1;
    end
    check("hold stable", {31'd0, bad}, 32'd0);
    @(negedge clk);
    Flush = 1'b1;
    @(posedge clk);
    #1 Flush = 1'b0;
    check("flush DONE OutValid", {31'd0, OutValid}, 32'd0);
    check("flush DONE InReady",  {31'd0, InReady},  32'd1);

    // Flush wins over InValid in IDLE.
    @(negedge clk);
    Op = 3'b000; SrcA = 32'd3; SrcB = 32'd4; InValid = 1'b1; Flush = 1'b1;
    @(posedge clk);
    #1 begin InValid = 1'b0; Flush = 1'b0; end
    check("flush blocks accept", {31'd0, Busy}, 32'd0);

    // Flush in CALC cycle 10.
    @(negedge clk);
    Op = 3'b000; SrcA = 32'd1234; SrcB = 32'd5678; InValid = 1'b1;
    @(posedge clk);
    #1 InValid = 1'b0;
    repeat (9) @(posedge clk);
    #1 check("mid-CALC Busy", {31'd0, Busy}, 32'd1);
    @(negedge clk);
    Flush = 1'b1;
    @(posedge clk);
    #1 Flush = 1'b0;
    check("flush CALC InReady", {31'd0, InReady}, 32'd1);
    check("flush CALC Busy",    {31'd0, Busy},    32'd0);
    bad = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1 if (OutValid) bad = 1'b1;
    end
    check("flush no OutValid", {31'd0, bad}, 32'd0);
    do_op(3'b000, 32'd3, 32'd4, res, lat, rdy_bad);
    check("MUL 3x4 after flush", res, 32'd12);
    check("MUL 3x4 latency", 32'(lat), 32'd33);
    drain();

    // Asynchronous reset mid-CALC, observed before any further clock edge.
    @(negedge clk);
    Op = 3'b101; SrcA = 32'hDEADBEEF; SrcB = 32'd3; InValid = 1'b1;
    @(posedge clk);
    #1 InValid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async rst OutValid", {31'd0, OutValid}, 32'd0);
    check("async rst Busy",     {31'd0, Busy},     32'd0);
    check("async rst InReady",  {31'd0, InReady},  32'd1);
    check("async rst Result",   Result,            32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(3'b101, 32'd100, 32'd7, res, lat, rdy_bad);
    check("DIVU 100/7 after reset", res, 32'd14);
    check("DIVU 100/7 latency", 32'(lat), 32'd33);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
